// File: rtl/uart_fifo_core_if.sv
// Processor-side command and write-back bus of the UART core.
interface uart_fifo_core_if;
  logic       UART_ENB;
  logic [2:0] instruction;
  logic [7:0] write_value;
  logic       wb_flag;
  logic [7:0] wb_data;

  modport master (
    output UART_ENB, instruction, write_value,
    input  wb_flag, wb_data
  );

  modport slave (
    input  UART_ENB, instruction, write_value,
    output wb_flag, wb_data
  );
endinterface

// File: rtl/uart_fifo_core.sv
// UART controller with baud down-counters, RX/TX FIFOs, sticky error flags and a
// command/write-back interface toward the processor.
//
// state     | meaning
// ST_IDLE   | line idle; RX waits for low, TX waits for FIFO data
// ST_START  | start bit (RX: half-bit check for false start)
// ST_DATA   | data bits, LSB first
// ST_PARITY | parity bit (only when parity is enabled)
// ST_STOP   | stop bit(s); RX resolves frame/parity/overrun here
module uart_fifo_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int RX_DEPTH     = 16,
  parameter int TX_DEPTH     = 16
) (
  input  logic             clock,
  input  logic             init_flag,
  uart_fifo_core_if.slave  bus,
  input  logic             rx,
  output logic             tx,
  output logic             irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic       PAR_ODD   = (PARITY_ODD != 0);
  localparam logic       PAR_EN    = (PARITY_EN != 0);

  localparam logic [2:0] OP_RXAVAIL = 3'b001;
  localparam logic [2:0] OP_READ    = 3'b010;
  localparam logic [2:0] OP_WRITE   = 3'b011;
  localparam logic [2:0] OP_STATUS  = 3'b100;
  localparam logic [2:0] OP_CLEAR   = 3'b101;
  localparam logic [2:0] OP_RXCOUNT = 3'b110;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  state_t               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  state_t               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic [RX_AW:0]       rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [TX_AW:0]       tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic                 parity_err_q, parity_err_d, frame_err_q, frame_err_d;
  logic                 rx_overrun_q, rx_overrun_d, tx_overflow_q, tx_overflow_d;
  logic                 wb_flag_q, wb_flag_d, irq_q, irq_d;
  logic [7:0]           wb_data_q, wb_data_d;

  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];

  logic [RX_AW:0]       rx_count;
  logic [TX_AW:0]       tx_count;
  logic                 rx_empty, rx_full, tx_empty, tx_full, tx_busy;
  logic [DATA_BITS-1:0] rx_head, tx_head;
  logic [2:0]           cmd_op;
  logic                 cmd_clear, rx_pop, rx_push, rx_push_req, tx_pop, tx_push, tx_push_req;
  logic                 set_frame, set_parity, tx_load;

  assign rx_count = rx_wr_q - rx_rd_q;
  assign tx_count = tx_wr_q - tx_rd_q;
  assign rx_empty = (rx_count == '0);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign rx_head  = rx_mem[rx_rd_q[RX_AW-1:0]];
  assign tx_head  = tx_mem[tx_rd_q[TX_AW-1:0]];
  assign tx_busy  = (tx_state_q != ST_IDLE) || !tx_empty;

  assign cmd_op      = bus.UART_ENB ? bus.instruction : 3'b000;
  assign cmd_clear   = (cmd_op == OP_CLEAR);
  assign rx_pop      = (cmd_op == OP_READ) && !rx_empty;
  assign tx_push_req = (cmd_op == OP_WRITE);
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);

  assign tx          = tx_q;
  assign irq         = irq_q;
  assign bus.wb_flag = wb_flag_q;
  assign bus.wb_data = wb_data_q;

  always_comb begin
    rx_s1_d     = rx;
    rx_s2_d     = rx_s1_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_par_d    = rx_par_q;
    rx_push_req = 1'b0;
    set_frame   = 1'b0;
    set_parity  = 1'b0;
    if (rx_state_q != ST_IDLE && rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      unique case (rx_state_q)
        ST_IDLE: begin
          if (!rx_s2_q) begin
            rx_state_d = ST_START;
            rx_cnt_d   = HALF_LOAD;
          end
        end
        ST_START: begin
          rx_cnt_d   = BIT_LOAD;
          rx_bit_d   = LAST_DATA;
          rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          rx_cnt_d   = BIT_LOAD;
          rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == '0) rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
          else                rx_bit_d   = rx_bit_q - 1'b1;
        end
        ST_PARITY: begin
          rx_cnt_d   = BIT_LOAD;
          rx_par_d   = rx_s2_q;
          rx_state_d = ST_STOP;
        end
        ST_STOP: begin
          rx_state_d = ST_IDLE;
          if (!rx_s2_q)                                            set_frame   = 1'b1;
          else if (PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD))) set_parity  = 1'b1;
          else                                                     rx_push_req = 1'b1;
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_load    = 1'b0;
    if (tx_state_q != ST_IDLE && tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else begin
      tx_cnt_d = BIT_LOAD;
      unique case (tx_state_q)
        ST_IDLE: tx_load = !tx_empty;
        ST_START: begin
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = LAST_DATA;
          tx_state_d = ST_DATA;
        end
        ST_DATA: begin
          if (tx_bit_q == '0) begin
            tx_d       = PAR_EN ? tx_par_q : 1'b1;
            tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
            tx_bit_d   = LAST_STOP;
          end else begin
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
            tx_bit_d   = tx_bit_q - 1'b1;
          end
        end
        ST_PARITY: begin
          tx_d       = 1'b1;
          tx_state_d = ST_STOP;
          tx_bit_d   = LAST_STOP;
        end
        ST_STOP: begin
          // Chain straight into the next frame so back-to-back bytes leave no gap.
          if (tx_bit_q != '0) tx_bit_d = tx_bit_q - 1'b1;
          else if (!tx_empty) tx_load  = 1'b1;
          else                tx_state_d = ST_IDLE;
        end
        default: tx_state_d = ST_IDLE;
      endcase
      if (tx_load) begin
        tx_shift_d = tx_head;
        tx_par_d   = (^tx_head) ^ PAR_ODD;
        tx_d       = 1'b0;
        tx_state_d = ST_START;
      end
    end
    tx_pop = tx_load;
  end

  always_comb begin
    rx_wr_d       = rx_wr_q + (RX_AW+1)'(rx_push);
    rx_rd_d       = rx_rd_q + (RX_AW+1)'(rx_pop);
    tx_wr_d       = tx_wr_q + (TX_AW+1)'(tx_push);
    tx_rd_d       = tx_rd_q + (TX_AW+1)'(tx_pop);
    parity_err_d  = (parity_err_q  & ~cmd_clear) | set_parity;
    frame_err_d   = (frame_err_q   & ~cmd_clear) | set_frame;
    rx_overrun_d  = (rx_overrun_q  & ~cmd_clear) | (rx_push_req && !rx_push);
    tx_overflow_d = (tx_overflow_q & ~cmd_clear) | (tx_push_req && !tx_push);
    irq_d         = !rx_empty | parity_err_q | frame_err_q | rx_overrun_q | tx_overflow_q;
    wb_flag_d     = 1'b0;
    wb_data_d     = 8'h00;
    unique case (cmd_op)
      OP_RXAVAIL: begin
        wb_flag_d = 1'b1;
        wb_data_d = {7'b0, !rx_empty};
      end
      OP_READ: begin
        wb_flag_d = 1'b1;
        wb_data_d = rx_empty ? 8'h00 : 8'(rx_head);
      end
      OP_STATUS: begin
        wb_flag_d = 1'b1;
        wb_data_d = {1'b0, tx_overflow_q, rx_overrun_q, frame_err_q,
                     parity_err_q, tx_busy, tx_full, !rx_empty};
      end
      OP_RXCOUNT: begin
        wb_flag_d = 1'b1;
        wb_data_d = 8'(rx_count);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_q[RX_AW-1:0]] <= rx_shift_q;
    if (tx_push) tx_mem[tx_wr_q[TX_AW-1:0]] <= bus.write_value[DATA_BITS-1:0];
  end

  always_ff @(posedge clock or negedge init_flag) begin
    if (!init_flag) begin
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      tx_state_q    <= ST_IDLE;
      tx_cnt_q      <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_q          <= 1'b1;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      wb_flag_q     <= 1'b0;
      wb_data_q     <= 8'h00;
      irq_q         <= 1'b0;
    end else begin
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      tx_state_q    <= tx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      tx_q          <= tx_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      wb_flag_q     <= wb_flag_d;
      wb_data_q     <= wb_data_d;
      irq_q         <= irq_d;
    end
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: three configurations share one clock, and a
// monitor per instance checks every write-back against the queued expectation.
module tb_uart_fifo_core;
  localparam int CPB = 16;
  localparam logic [2:0] OP_RXAVAIL = 3'd1, OP_READ = 3'd2, OP_WRITE = 3'd3,
                         OP_STATUS = 3'd4, OP_CLEAR = 3'd5, OP_RXCOUNT = 3'd6;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [2:0] rst_n = 3'b000;
  logic [2:0] enb   = 3'b000;
  logic [2:0] rxd   = 3'b111;
  logic [2:0] loop  = 3'b101;
  logic [2:0] instr [3];
  logic [7:0] wval  [3];
  logic       tx0, tx1, tx2, irq0, irq1, irq2;
  int         checks = 0;
  int         errors = 0;
  logic [10:0] exp_q0 [$];
  logic [10:0] exp_q1 [$];
  logic [10:0] exp_q2 [$];

  uart_fifo_core_if bus0 ();
  uart_fifo_core_if bus1 ();
  uart_fifo_core_if bus2 ();
  assign bus0.UART_ENB = enb[0];
  assign bus0.instruction = instr[0];
  assign bus0.write_value = wval[0];
  assign bus1.UART_ENB = enb[1];
  assign bus1.instruction = instr[1];
  assign bus1.write_value = wval[1];
  assign bus2.UART_ENB = enb[2];
  assign bus2.instruction = instr[2];
  assign bus2.write_value = wval[2];

  uart_fifo_core #(.CLKS_PER_BIT(CPB)) dut0 (
    .clock(clock), .init_flag(rst_n[0]), .bus(bus0),
    .rx(loop[0] ? tx0 : rxd[0]), .tx(tx0), .irq(irq0));
  uart_fifo_core #(.CLKS_PER_BIT(CPB), .RX_DEPTH(4), .TX_DEPTH(4)) dut1 (
    .clock(clock), .init_flag(rst_n[1]), .bus(bus1),
    .rx(loop[1] ? tx1 : rxd[1]), .tx(tx1), .irq(irq1));
  uart_fifo_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_ODD(1), .STOP_BITS(2)) dut2 (
    .clock(clock), .init_flag(rst_n[2]), .bus(bus2),
    .rx(loop[2] ? tx2 : rxd[2]), .tx(tx2), .irq(irq2));

  function automatic logic get_tx(input int n);
    return (n == 0) ? tx0 : (n == 1) ? tx1 : tx2;
  endfunction

  function automatic logic get_irq(input int n);
    return (n == 0) ? irq0 : (n == 1) ? irq1 : irq2;
  endfunction

  function automatic logic get_wbf(input int n);
    return (n == 0) ? bus0.wb_flag : (n == 1) ? bus1.wb_flag : bus2.wb_flag;
  endfunction

  function automatic logic [7:0] get_wbd(input int n);
    return (n == 0) ? bus0.wb_data : (n == 1) ? bus1.wb_data : bus2.wb_data;
  endfunction

  function automatic string op_name(input logic [2:0] op);
    case (op)
      OP_RXAVAIL: return "RXAVAIL";
      OP_READ:    return "READ";
      OP_STATUS:  return "STATUS";
      OP_RXCOUNT: return "RXCOUNT";
      default:    return "OTHER";
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  task automatic mon(input int n, input logic [7:0] got);
    logic [10:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (n)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL dut%0d unexpected wb_flag: wb_data=0x%02h with no command pending", n, got);
    end else begin
      check($sformatf("dut%0d %s", n, op_name(e[10:8])), got, e[7:0]);
    end
  endtask

  always @(negedge clock) if (bus0.wb_flag) mon(0, bus0.wb_data);
  always @(negedge clock) if (bus1.wb_flag) mon(1, bus1.wb_data);
  always @(negedge clock) if (bus2.wb_flag) mon(2, bus2.wb_data);

  // Called on a falling edge; returns on the next one with the strobe dropped.
  task automatic cmd(input int n, input logic [2:0] op, input logic [7:0] val, input logic [7:0] exp);
    enb[n]   = 1'b1;
    instr[n] = op;
    wval[n]  = val;
    if (op == OP_RXAVAIL || op == OP_READ || op == OP_STATUS || op == OP_RXCOUNT) begin
      case (n)
        0: exp_q0.push_back({op, exp});
        1: exp_q1.push_back({op, exp});
        default: exp_q2.push_back({op, exp});
      endcase
    end
    @(negedge clock);
    enb[n]   = 1'b0;
    instr[n] = 3'd0;
    wval[n]  = 8'h00;
  endtask

  task automatic drive_bit(input int n, input logic v, input int cycles);
    rxd[n] = v;
    repeat (cycles) @(negedge clock);
  endtask

  // 8 data bits, even parity; optionally corrupt the parity or hold stop low for 12 cycles.
  task automatic send_frame(input int n, input logic [7:0] data, input bit bad_par, input bit bad_stop);
    logic p;
    p = (^data) ^ bad_par;
    drive_bit(n, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(n, data[i], CPB);
    drive_bit(n, p, CPB);
    if (bad_stop) begin
      drive_bit(n, 1'b0, 12);
      drive_bit(n, 1'b1, 2 * CPB);
    end else begin
      drive_bit(n, 1'b1, CPB);
    end
  endtask

  task automatic wait_tx_low(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (get_tx(n) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int mism;
    logic [10:0] fb;
    for (int i = 0; i < 3; i++) begin
      instr[i] = 3'd0;
      wval[i]  = 8'h00;
    end
    repeat (3) @(negedge clock);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("dut%0d reset tx", n), {7'b0, get_tx(n)}, 8'h01);
      check($sformatf("dut%0d reset irq", n), {7'b0, get_irq(n)}, 8'h00);
      check($sformatf("dut%0d reset wb_flag", n), {7'b0, get_wbf(n)}, 8'h00);
      check($sformatf("dut%0d reset wb_data", n), get_wbd(n), 8'h00);
    end
    rst_n = 3'b111;
    @(negedge clock);

    // dut0 loopback
    cmd(0, OP_WRITE, 8'hA5, 8'h00);
    cmd(0, OP_WRITE, 8'h3C, 8'h00);
    repeat (420) @(negedge clock);
    cmd(0, OP_RXAVAIL, 8'h00, 8'h01);
    cmd(0, OP_READ, 8'h00, 8'hA5);
    cmd(0, OP_READ, 8'h00, 8'h3C);
    cmd(0, OP_RXCOUNT, 8'h00, 8'h00);
    cmd(0, OP_STATUS, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    check("dut0 irq after drain", {7'b0, irq0}, 8'h00);

    // dut0 frame timing for 0x01: start, data LSB first, even parity, stop
    fb = {1'b1, 1'b1, 8'h01, 1'b0};
    cmd(0, OP_WRITE, 8'h01, 8'h00);
    wait_tx_low(0, 8, ok);
    check("dut0 tx start edge seen", {7'b0, ok}, 8'h01);
    mism = 0;
    for (int i = 0; i < 176; i++) begin
      if (tx0 !== fb[i / 16]) mism++;
      @(negedge clock);
    end
    check("dut0 frame 0x01 bit-cycle errors", 8'(mism), 8'h00);
    check("dut0 tx idle after frame", {7'b0, tx0}, 8'h01);
    repeat (10) @(negedge clock);
    cmd(0, OP_READ, 8'h00, 8'h01);

    // dut0 RX error handling on a driven line
    loop[0] = 1'b0;
    repeat (4) @(negedge clock);
    send_frame(0, 8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    cmd(0, OP_STATUS, 8'h00, 8'h08);
    cmd(0, OP_RXCOUNT, 8'h00, 8'h00);
    check("dut0 irq on parity error", {7'b0, irq0}, 8'h01);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    repeat (4) @(negedge clock);
    cmd(0, OP_STATUS, 8'h00, 8'h18);
    cmd(0, OP_CLEAR, 8'h00, 8'h00);
    cmd(0, OP_STATUS, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    check("dut0 irq after clear", {7'b0, irq0}, 8'h00);
    send_frame(0, 8'h96, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    cmd(0, OP_READ, 8'h00, 8'h96);

    // dut0 false start glitch
    drive_bit(0, 1'b0, 4);
    drive_bit(0, 1'b1, 40);
    cmd(0, OP_STATUS, 8'h00, 8'h00);
    cmd(0, OP_RXCOUNT, 8'h00, 8'h00);
    cmd(0, OP_READ, 8'h00, 8'h00);

    // dut1 RX overrun with a 4-entry FIFO
    send_frame(1, 8'h11, 1'b0, 1'b0);
    send_frame(1, 8'h22, 1'b0, 1'b0);
    send_frame(1, 8'h33, 1'b0, 1'b0);
    send_frame(1, 8'h44, 1'b0, 1'b0);
    send_frame(1, 8'h55, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    cmd(1, OP_RXCOUNT, 8'h00, 8'h04);
    cmd(1, OP_STATUS, 8'h00, 8'h21);
    check("dut1 irq on overrun", {7'b0, irq1}, 8'h01);
    cmd(1, OP_READ, 8'h00, 8'h11);
    cmd(1, OP_READ, 8'h00, 8'h22);
    cmd(1, OP_READ, 8'h00, 8'h33);
    cmd(1, OP_READ, 8'h00, 8'h44);
    cmd(1, OP_RXAVAIL, 8'h00, 8'h00);
    cmd(1, OP_CLEAR, 8'h00, 8'h00);
    cmd(1, OP_STATUS, 8'h00, 8'h00);

    // dut1 TX overflow: one byte leaves for the shifter, four fill the FIFO, the sixth drops
    for (int i = 0; i < 6; i++) cmd(1, OP_WRITE, 8'(8'h80 + i), 8'h00);
    cmd(1, OP_STATUS, 8'h00, 8'h46);

    // dut2 reset mid-frame, then 7-bit odd-parity two-stop loopback
    cmd(2, OP_WRITE, 8'h55, 8'h00);
    wait_tx_low(2, 8, ok);
    check("dut2 tx start edge seen", {7'b0, ok}, 8'h01);
    repeat (70) @(negedge clock);
    check("dut2 tx during data bit 3", {7'b0, tx2}, 8'h00);
    rst_n[2] = 1'b0;
    #1;
    check("dut2 tx async reset", {7'b0, tx2}, 8'h01);
    check("dut2 wb_flag in reset", {7'b0, bus2.wb_flag}, 8'h00);
    repeat (3) @(negedge clock);
    rst_n[2] = 1'b1;
    repeat (2) @(negedge clock);
    cmd(2, OP_STATUS, 8'h00, 8'h00);
    cmd(2, OP_RXCOUNT, 8'h00, 8'h00);
    cmd(2, OP_WRITE, 8'h7F, 8'h00);
    cmd(2, OP_WRITE, 8'hD3, 8'h00);
    repeat (400) @(negedge clock);
    cmd(2, OP_RXCOUNT, 8'h00, 8'h02);
    cmd(2, OP_READ, 8'h00, 8'h7F);
    cmd(2, OP_READ, 8'h00, 8'h53);
    cmd(2, OP_STATUS, 8'h00, 8'h00);

    repeat (3) @(negedge clock);
    check("dut0 pending write-backs", 8'(exp_q0.size()), 8'h00);
    check("dut1 pending write-backs", 8'(exp_q1.size()), 8'h00);
    check("dut2 pending write-backs", 8'(exp_q2.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
